// File: rtl/ps2_rx_keyevent.sv
// Native PS/2 keyboard receiver producing the toggle-style 11-bit key event word.
// Conditions the raw open-drain lines, frames device-to-host bytes and folds E0/F0 prefixes.
module ps2_rx_keyevent #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 96000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TimeMax = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity,
    StStop
  } state_e;

  // Input conditioning
  logic          clk_meta_q, clk_sync_q;
  logic          data_meta_q, data_sync_q;
  logic          clk_filt_q, clk_filt_d;
  logic          clk_filt_prev_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;

  // Framing
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic          pok_q, pok_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          dec_q, dec_d;
  logic          err_q, err_d;

  // Decode
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [10:0]   key_q, key_d;
  logic          strobe_q, strobe_d;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_meta_q      <= 1'b1;
      clk_sync_q      <= 1'b1;
      data_meta_q     <= 1'b1;
      data_sync_q     <= 1'b1;
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      filt_cnt_q      <= '0;
    end else begin
      clk_meta_q      <= ps2_clk_in;
      clk_sync_q      <= clk_meta_q;
      data_meta_q     <= ps2_data_in;
      data_sync_q     <= data_meta_q;
      clk_filt_q      <= clk_filt_d;
      clk_filt_prev_q <= clk_filt_q;
      filt_cnt_q      <= filt_cnt_d;
    end
  end

  // The filtered clock only follows the synced line after FILTER_LEN cycles of disagreement.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != clk_filt_q) begin
      if (filt_cnt_q == FiltMax) begin
        clk_filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = clk_filt_prev_q & ~clk_filt_q;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      par_q     <= 1'b0;
      pok_q     <= 1'b0;
      tcnt_q    <= '0;
      dec_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      pok_q     <= pok_d;
      tcnt_q    <= tcnt_d;
      dec_q     <= dec_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    par_d     = par_q;
    pok_d     = pok_q;
    tcnt_d    = tcnt_q;
    dec_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          if (!data_sync_q) begin
            state_d   = StShift;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (fall) begin
          sr_d      = {data_sync_q, sr_q[7:1]};
          par_d     = par_q ^ data_sync_q;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (fall) begin
          pok_d   = par_q ^ data_sync_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          if (data_sync_q && pok_q) begin
            dec_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Inter-edge watchdog; the abort check precedes the increment so the count never wraps.
    if (state_q == StIdle) begin
      tcnt_d = '0;
    end else if (fall) begin
      tcnt_d = '0;
    end else if (tcnt_q == TimeMax) begin
      tcnt_d  = '0;
      err_d   = 1'b1;
      state_d = StIdle;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      key_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      ext_q    <= ext_d;
      rel_q    <= rel_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
    end
  end

  // Runs the cycle after a good stop bit; sr_q stays intact until the next frame's first data bit.
  always_comb begin
    ext_d    = ext_q;
    rel_d    = rel_q;
    key_d    = key_q;
    strobe_d = 1'b0;
    if (dec_q) begin
      unique case (sr_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: rel_d = 1'b1;
        8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
        default: begin
          key_d    = {~key_q[10], ~rel_q, ext_q, sr_q};
          strobe_d = 1'b1;
          ext_d    = 1'b0;
          rel_d    = 1'b0;
        end
      endcase
    end
  end

  assign ps2_key    = key_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_rx_keyevent.sv
// Bench for ps2_rx_keyevent: bit-banged PS/2 frames against a byte-level event model.
module tb_ps2_rx_keyevent;

  localparam int FL = 8;
  localparam int TO = 400;
  localparam int HP = 40;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  ps2_rx_keyevent #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_sys    (clk_sys),
    .RESET_N    (rst_n),
    .ps2_clk_in (ps2_clk),
    .ps2_data_in(ps2_data),
    .ps2_key    (ps2_key),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
  int strobe_cyc = 0, err_cyc = 0, last_fall = 0;
  logic prev_strobe = 1'b0, prev_err = 1'b0;

  // Reference state at event level
  logic [10:0] exp_key = '0;
  logic        m_ext = 1'b0, m_rel = 1'b0;
  int          exp_strobes = 0;
  int          exp_errs = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (key_strobe) begin
      strobe_cnt++;
      strobe_cyc = cyc;
      if (prev_strobe) wide_cnt++;
    end
    if (frame_err) begin
      err_cnt++;
      err_cyc = cyc;
      if (prev_err) wide_cnt++;
    end
    if (key_strobe && frame_err) both_cnt++;
    prev_strobe = key_strobe;
    prev_err    = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Sends the first nbits of an 11-bit frame; glitch>0 adds a short low pulse in each high phase.
  task automatic send_frame(input logic [7:0] b, input int hp, input bit bad_par,
                            input int nbits, input int glitch);
    logic [10:0] bits;
    bits = {1'b1, bad_par ? ^b : ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(hp);
      if (glitch > 0) begin
        ps2_clk = 1'b0;
        wait_cyc(glitch);
        ps2_clk = 1'b1;
        wait_cyc(hp);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(hp);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * hp);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
        exp_key = {~exp_key[10], ~m_rel, m_ext, b};
        exp_strobes++;
      end
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hp);
    send_frame(b, hp, 1'b0, 11, 0);
    model_byte(b);
  endtask

  initial begin
    int d;
    int lat;
    logic [7:0] code;

    // Reset
    wait_cyc(4);
    check("reset_key", ps2_key, 11'h000);
    check("reset_strobe", key_strobe, 1'b0);
    check("reset_err", frame_err, 1'b0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Clean make and latency from the raw stop-bit edge
    send_byte(8'h1C, HP);
    check("make_key", ps2_key, 11'h61C);
    check("make_strobes", strobe_cnt, 1);
    lat = strobe_cyc - last_fall;
    check("make_latency", (lat >= FL + 3 && lat <= FL + 5), 1'b1);

    // Break and extended
    send_byte(8'hF0, HP); send_byte(8'h1C, HP);
    check("break_key", ps2_key, 11'h01C);
    send_byte(8'hE0, HP); send_byte(8'h75, HP);
    check("ext_make_key", ps2_key, 11'h775);
    send_byte(8'hE0, HP); send_byte(8'hF0, HP); send_byte(8'h75, HP);
    check("ext_break_key", ps2_key, 11'h175);
    check("seq_strobes", strobe_cnt, 4);
    check("no_err_yet", err_cnt, 0);

    // Parity error then recovery
    send_frame(8'h1C, HP, 1'b1, 11, 0);
    exp_errs++;
    check("parity_err", err_cnt, exp_errs);
    check("parity_nostrobe", strobe_cnt, exp_strobes);
    check("parity_key_kept", ps2_key, exp_key);
    send_byte(8'h29, HP);
    check("after_parity_code", ps2_key[7:0], 8'h29);
    check("after_parity_make", ps2_key[9], 1'b1);

    // Timeout after start + 4 data bits
    send_frame(8'h55, HP, 1'b0, 5, 0);
    d = 0;
    while (err_cnt == exp_errs && d < TO + FL + 100) begin
      wait_cyc(1);
      d++;
    end
    exp_errs++;
    check("timeout_err", err_cnt, exp_errs);
    lat = err_cyc - last_fall;
    check("timeout_delay", (lat >= TO + FL + 1 && lat <= TO + FL + 5), 1'b1);
    wait_cyc(50);
    check("timeout_single", err_cnt, exp_errs);
    send_byte(8'h14, HP);
    check("after_timeout_key", ps2_key, exp_key);

    // Glitch rejection
    send_frame(8'h3C, HP, 1'b0, 11, FL - 2);
    model_byte(8'h3C);
    check("glitch_key", ps2_key, exp_key);
    check("glitch_noerr", err_cnt, exp_errs);
    ps2_data = 1'b1;
    ps2_clk = 1'b0; wait_cyc(FL - 2); ps2_clk = 1'b1; wait_cyc(HP);
    check("short_pulse_ignored", err_cnt, exp_errs);
    ps2_clk = 1'b0; wait_cyc(FL + 2); ps2_clk = 1'b1; wait_cyc(HP);
    exp_errs++;
    check("long_pulse_edge", err_cnt, exp_errs);

    // Reset mid-frame, then discarded codes
    send_frame(8'h5A, HP, 1'b0, 6, 0);
    rst_n = 1'b0;
    wait_cyc(3);
    check("midreset_key", ps2_key, 11'h000);
    check("midreset_strobe", key_strobe, 1'b0);
    rst_n = 1'b1;
    exp_key = '0; m_ext = 1'b0; m_rel = 1'b0;
    wait_cyc(4);
    d = strobe_cnt;
    send_byte(8'hAA, HP); send_byte(8'hE1, HP); send_byte(8'h1C, HP);
    check("discard_one_strobe", strobe_cnt - d, 1);
    check("discard_key", ps2_key, 11'h61C);
    exp_strobes = strobe_cnt;

    // Randomized events
    for (int n = 0; n < 6; n++) begin
      int hp;
      hp = 30 + $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) send_byte(8'hFA, hp);
      if ($urandom_range(0, 1) == 1) send_byte(8'hE0, hp);
      if ($urandom_range(0, 1) == 1) send_byte(8'hF0, hp);
      code = 8'($urandom_range(1, 127));
      send_byte(code, hp);
      check("rand_key", ps2_key, exp_key);
      check("rand_strobes", strobe_cnt, exp_strobes);
    end

    check("final_errs", err_cnt, exp_errs);
    check("never_both", both_cnt, 0);
    check("pulses_one_cycle", wide_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
